// File: rtl/fp_iter_divider.sv
// Multi-cycle IEEE-754 single-precision divider, io_out_q = io_in_a / io_in_b.
// Restoring mantissa division (one quotient bit per cycle), truncating, denormals flushed to zero.
module fp_iter_divider (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [31:0] io_in_a,
   input  logic [31:0] io_in_b,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [31:0] io_out_q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      NORM = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   state_t             state_q,     state_d;
   logic               in_ready_q,  in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [31:0]        result_q,    result_d;
   logic               sign_q,      sign_d;
   logic [7:0]         ea_q,        ea_d;
   logic [7:0]         eb_q,        eb_d;
   logic [23:0]        ma_q,        ma_d;
   logic [23:0]        mb_q,        mb_d;
   logic signed [9:0]  exp_q,       exp_d;
   logic [24:0]        rem_q,       rem_d;
   logic [24:0]        quo_q,       quo_d;
   logic [4:0]         cnt_q,       cnt_d;

   logic               accept_s;
   logic               sign_s;
   logic               special_s;
   logic [31:0]        special_q_s;
   logic               rem_ge_s;
   logic [24:0]        rem_sub_s;
   logic signed [9:0]  exp_norm_s;
   logic [22:0]        frac_s;
   logic [31:0]        norm_q_s;

   function automatic logic is_zero(input logic [31:0] x);
      is_zero = (x[30:23] == 8'd0);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      is_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
   endfunction

   function automatic logic is_nan(input logic [31:0] x);
      is_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   assign accept_s     = io_in_valid & in_ready_q & (state_q == IDLE);
   assign io_in_ready  = in_ready_q;
   assign io_out_valid = out_valid_q;
   assign io_out_q     = result_q;

   // Operand classification: special results bypass the iterative datapath.
   always_comb begin
      sign_s      = io_in_a[31] ^ io_in_b[31];
      special_s   = 1'b1;
      special_q_s = 32'h0000_0000;
      if (is_nan(io_in_a) || is_nan(io_in_b) ||
          (is_zero(io_in_a) && is_zero(io_in_b)) ||
          (is_inf(io_in_a) && is_inf(io_in_b))) begin
         special_q_s = QNAN;
      end else if (is_inf(io_in_a) || is_zero(io_in_b)) begin
         special_q_s = {sign_s, 31'h7F80_0000};
      end else if (is_zero(io_in_a) || is_inf(io_in_b)) begin
         special_q_s = {sign_s, 31'd0};
      end else begin
         special_s   = 1'b0;
         special_q_s = 32'h0000_0000;
      end
   end

   // Restoring step: the remainder never exceeds twice the divisor, so 25 bits suffice.
   always_comb begin
      rem_ge_s  = (rem_q >= {1'b0, mb_q});
      rem_sub_s = rem_q - {1'b0, mb_q};
   end

   // Normalisation of the 25-bit quotient and exponent range check.
   always_comb begin
      if (quo_q[24]) begin
         exp_norm_s = exp_q + 10'sd1;
         frac_s     = quo_q[23:1];
      end else begin
         exp_norm_s = exp_q;
         frac_s     = quo_q[22:0];
      end
      if (exp_norm_s >= 10'sd255) begin
         norm_q_s = {sign_q, 8'hFF, 23'd0};
      end else if (exp_norm_s <= 10'sd0) begin
         norm_q_s = {sign_q, 31'd0};
      end else begin
         norm_q_s = {sign_q, exp_norm_s[7:0], frac_s};
      end
   end

   // Next-state logic for the control FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               if (special_s) begin
                  state_d = DONE;
               end else begin
                  state_d = DIV;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DIV: begin
            if (cnt_q == 5'd25) begin
               state_d = NORM;
            end else begin
               state_d = DIV;
            end
         end
         NORM: state_d = DONE;
         DONE: begin
            if (io_out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state; DIV cycle 0 seeds the remainder and exponent, cycles 1..25 each yield one bit.
   always_comb begin
      sign_d      = sign_q;
      ea_d        = ea_q;
      eb_d        = eb_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      exp_d       = exp_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               sign_d = sign_s;
               ea_d   = io_in_a[30:23];
               eb_d   = io_in_b[30:23];
               ma_d   = {1'b1, io_in_a[22:0]};
               mb_d   = {1'b1, io_in_b[22:0]};
               rem_d  = 25'd0;
               quo_d  = 25'd0;
               cnt_d  = 5'd0;
               exp_d  = 10'sd0;
               if (special_s) begin
                  result_d = special_q_s;
               end else begin
                  result_d = result_q;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         DIV: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd0) begin
               rem_d = {1'b0, ma_q};
               quo_d = 25'd0;
               exp_d = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd126;
            end else if (rem_ge_s) begin
               rem_d = {rem_sub_s[23:0], 1'b0};
               quo_d = {quo_q[23:0], 1'b1};
            end else begin
               rem_d = {rem_q[23:0], 1'b0};
               quo_d = {quo_q[23:0], 1'b0};
            end
         end
         NORM: result_d = norm_q_s;
         DONE: result_d = result_q;
         default: result_d = result_q;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         result_q    <= 32'h0000_0000;
         sign_q      <= 1'b0;
         ea_q        <= 8'd0;
         eb_q        <= 8'd0;
         ma_q        <= 24'd0;
         mb_q        <= 24'd0;
         exp_q       <= 10'sd0;
         rem_q       <= 25'd0;
         quo_q       <= 25'd0;
         cnt_q       <= 5'd0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         sign_q      <= sign_d;
         ea_q        <= ea_d;
         eb_q        <= eb_d;
         ma_q        <= ma_d;
         mb_q        <= mb_d;
         exp_q       <= exp_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule
